// File: rtl/uxn_stack_ctrl.sv
// Data-stack controller: owns the stack RAM and serialises core POP/PUSH/CLEAR
// and debug indexed accesses through one FSM with a round-robin arbiter.
module uxn_stack_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic [1:0]            core_op,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_ack,
  output logic                  core_err,
  output logic [DATA_W-1:0]     core_a,
  output logic [DATA_W-1:0]     core_b,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DEPTH_LOG2-1:0] dbg_idx,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [DEPTH_LOG2:0]   depth
);

  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(1 << DEPTH_LOG2);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR, S_DONE} state_e;
  typedef enum logic [1:0] {OP_POP1 = 2'b00, OP_POP2 = 2'b01,
                            OP_PUSH = 2'b10, OP_CLEAR = 2'b11} op_e;
  typedef enum logic {RR_CORE = 1'b0, RR_DBG = 1'b1} rr_e;

  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

  state_e            state_q, state_d;
  logic [CW-1:0]     depth_q, depth_d;
  rr_e               rr_last_q, rr_last_d;
  logic              grant_dbg_q, grant_dbg_d;
  op_e               op_q, op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              core_ack_q, core_ack_d;
  logic              core_err_q, core_err_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] core_a_q, core_a_d;
  logic [DATA_W-1:0] core_b_q, core_b_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              ram_we;
  logic              take_dbg;
  logic [DATA_W-1:0] rd_word;

  // Read word is captured straight into the result registers, giving a
  // synchronous read with data available in the state after the access.
  assign rd_word = mem[addr_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    depth_d     = depth_q;
    rr_last_d   = rr_last_q;
    grant_dbg_d = grant_dbg_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    core_ack_d  = 1'b0;
    core_err_d  = 1'b0;
    dbg_ack_d   = 1'b0;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    dbg_rdata_d = dbg_rdata_q;
    ram_we      = 1'b0;
    take_dbg    = dbg_req && (!core_req || rr_last_q == RR_CORE);

    unique case (state_q)
      S_IDLE: begin
        if (core_req || dbg_req) begin
          rr_last_d   = take_dbg ? RR_DBG : RR_CORE;
          grant_dbg_d = take_dbg;
          if (take_dbg) begin
            addr_d  = dbg_idx;
            wdata_d = dbg_wdata;
            state_d = dbg_we ? S_WR : S_RD0;
          end else begin
            op_d    = op_e'(core_op);
            wdata_d = core_wdata;
            addr_d  = depth_q[AW-1:0] - ADDR_ONE;
            unique case (op_e'(core_op))
              OP_POP1: state_d = (depth_q < CNT_ONE) ? S_DONE : S_RD0;
              OP_POP2: state_d = (depth_q < CNT_TWO) ? S_DONE : S_RD0;
              OP_PUSH: begin
                addr_d  = depth_q[AW-1:0];
                state_d = (depth_q == CNT_FULL) ? S_DONE : S_WR;
              end
              OP_CLEAR: begin
                depth_d = '0;
                state_d = S_DONE;
              end
            endcase
            // Reaching DONE directly from IDLE means CLEAR or a rejected op.
            if (state_d == S_DONE) begin
              core_ack_d = 1'b1;
              core_err_d = (op_e'(core_op) != OP_CLEAR);
            end
          end
        end
      end
      S_RD0: begin
        if (grant_dbg_q) begin
          dbg_rdata_d = rd_word;
          dbg_ack_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          core_b_d = rd_word;
          if (op_q == OP_POP1) begin
            core_a_d   = '0;
            depth_d    = depth_q - CNT_ONE;
            core_ack_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            addr_d  = addr_q - ADDR_ONE;
            state_d = S_RD1;
          end
        end
      end
      S_RD1: begin
        core_a_d   = rd_word;
        depth_d    = depth_q - CNT_TWO;
        core_ack_d = 1'b1;
        state_d    = S_DONE;
      end
      S_WR: begin
        ram_we = 1'b1;
        if (grant_dbg_q) begin
          dbg_ack_d = 1'b1;
        end else begin
          depth_d    = depth_q + CNT_ONE;
          core_ack_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the RAM has no reset; contents survive reset and only depth bounds validity.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[addr_q] <= wdata_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      rr_last_q   <= RR_DBG;
      grant_dbg_q <= 1'b0;
      op_q        <= OP_POP1;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_ack_q  <= 1'b0;
      core_err_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      rr_last_q   <= rr_last_d;
      grant_dbg_q <= grant_dbg_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_ack_q  <= core_ack_d;
      core_err_q  <= core_err_d;
      dbg_ack_q   <= dbg_ack_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign core_ack  = core_ack_q;
  assign core_err  = core_err_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_uxn_stack_ctrl.sv
// Self-checking bench for uxn_stack_ctrl: directed scenarios plus random
// traffic compared against an array/counter model of the stack.
module tb_uxn_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic [1:0]  core_op;
  logic [15:0] core_wdata;
  logic        core_ack;
  logic        core_err;
  logic [15:0] core_a;
  logic [15:0] core_b;
  logic        dbg_req;
  logic        dbg_we;
  logic [7:0]  dbg_idx;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic [8:0]  depth;

  uxn_stack_ctrl #(.DATA_W(16), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_op(core_op), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_a(core_a), .core_b(core_b),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_idx(dbg_idx), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .depth(depth)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] POP1 = 2'b00, POP2 = 2'b01, PUSH = 2'b10, CLEAR = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stack is m_mem[0 .. m_depth-1]; result registers hold.
  logic [15:0] m_mem [256];
  bit          m_known [256];
  int          m_depth;
  logic [15:0] exp_a, exp_b, exp_rdata;
  bit          m_last_dbg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_depth    = 0;
    exp_a      = '0;
    exp_b      = '0;
    exp_rdata  = '0;
    m_last_dbg = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; core_req = 1'b0; dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic core_txn(input logic [1:0] op, input logic [15:0] wd);
    int lat, exp_lat, nd;
    bit got, exp_err;
    logic [15:0] na, nb;
    exp_err = 1'b0; nd = m_depth; na = exp_a; nb = exp_b; exp_lat = 1;
    case (op)
      POP1: if (m_depth < 1) exp_err = 1'b1;
            else begin nb = m_mem[m_depth-1]; na = '0; nd = m_depth - 1; exp_lat = 2; end
      POP2: if (m_depth < 2) exp_err = 1'b1;
            else begin nb = m_mem[m_depth-1]; na = m_mem[m_depth-2]; nd = m_depth - 2; exp_lat = 3; end
      PUSH: if (m_depth == 256) exp_err = 1'b1;
            else begin nd = m_depth + 1; exp_lat = 2; end
      default: nd = 0;
    endcase
    @(posedge clk); #1;
    core_req = 1'b1; core_op = op; core_wdata = wd;
    got = 1'b0; lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (core_ack) got = 1'b1;
    end
    core_req = 1'b0;
    check("core_ack_seen", 32'(got), 32'd1);
    check("core_latency", lat, exp_lat);
    check("core_err", 32'(core_err), 32'(exp_err));
    check("core_a", 32'(core_a), 32'(na));
    check("core_b", 32'(core_b), 32'(nb));
    check("depth_after_core", 32'(depth), nd);
    if (op == PUSH && !exp_err) begin
      m_mem[m_depth] = wd;
      m_known[m_depth] = 1'b1;
    end
    m_depth = nd; exp_a = na; exp_b = nb; m_last_dbg = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [7:0] idx, input logic [15:0] wd);
    int lat;
    bit got, rd_known;
    rd_known = m_known[idx];
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = we; dbg_idx = idx; dbg_wdata = wd;
    got = 1'b0; lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (dbg_ack) got = 1'b1;
    end
    dbg_req = 1'b0;
    check("dbg_ack_seen", 32'(got), 32'd1);
    check("dbg_latency", lat, 2);
    check("depth_after_dbg", 32'(depth), m_depth);
    if (we) begin
      check("dbg_rdata_hold", 32'(dbg_rdata), 32'(exp_rdata));
      m_mem[idx] = wd;
      m_known[idx] = 1'b1;
    end else if (rd_known) begin
      exp_rdata = m_mem[idx];
      check("dbg_rdata", 32'(dbg_rdata), 32'(exp_rdata));
    end
    m_last_dbg = 1'b1;
  endtask

  // Core PUSH and debug read raised in the same cycle and both held.
  task automatic tie(input logic [15:0] wd, input logic [7:0] idx);
    bit core_first;
    int cyc, cyc_core, cyc_dbg;
    logic [15:0] rd_exp;
    core_first = m_last_dbg;
    if (core_first) begin
      m_mem[m_depth] = wd; m_known[m_depth] = 1'b1;
      rd_exp = m_mem[idx];
    end else begin
      rd_exp = m_mem[idx];
      m_mem[m_depth] = wd; m_known[m_depth] = 1'b1;
    end
    @(posedge clk); #1;
    core_req = 1'b1; core_op = PUSH; core_wdata = wd;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_idx = idx;
    cyc = 0; cyc_core = -1; cyc_dbg = -1;
    while ((cyc_core < 0 || cyc_dbg < 0) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (core_ack) begin cyc_core = cyc; core_req = 1'b0;
        check("tie_core_err", 32'(core_err), 32'd0); end
      if (dbg_ack) begin cyc_dbg = cyc; dbg_req = 1'b0;
        check("tie_dbg_rdata", 32'(dbg_rdata), 32'(rd_exp)); end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    check("tie_core_ack_cycle", cyc_core, core_first ? 2 : 5);
    check("tie_dbg_ack_cycle", cyc_dbg, core_first ? 5 : 2);
    m_depth++;
    check("tie_depth", 32'(depth), m_depth);
    exp_rdata = rd_exp;
    m_last_dbg = core_first;
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_op = POP1; core_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_idx = '0; dbg_wdata = '0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    apply_reset();

    // Reset state
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_core_ack", 32'(core_ack), 32'd0);
    check("rst_core_err", 32'(core_err), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_core_a", 32'(core_a), 32'd0);
    check("rst_core_b", 32'(core_b), 32'd0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);

    // Tie from reset: core wins, then a core-only grant makes debug win next
    tie(16'h00A1, 8'd0);
    core_txn(PUSH, 16'h00A2);
    tie(16'h00A3, 8'd1);
    core_txn(CLEAR, 16'h0);

    // PUSH, PUSH, POP2
    apply_reset();
    core_txn(PUSH, 16'h0003);
    core_txn(PUSH, 16'h0005);
    check("two_pushes_depth", 32'(depth), 32'd2);
    core_txn(POP2, 16'h0);

    // Underflow errors
    core_txn(POP1, 16'h0);
    core_txn(PUSH, 16'h0077);
    core_txn(POP2, 16'h0);
    core_txn(CLEAR, 16'h0);

    // Debug write then pop sees it; debug read leaves depth alone
    core_txn(PUSH, 16'h0011);
    core_txn(PUSH, 16'h0022);
    dbg_txn(1'b1, 8'd1, 16'hBEEF);
    core_txn(POP1, 16'h0);
    check("pop_sees_dbg_write", 32'(core_b), 32'h0000BEEF);
    dbg_txn(1'b0, 8'd0, 16'h0);
    check("dbg_read_idx0", 32'(dbg_rdata), 32'h00000011);

    // Reset in the middle of POP2 (during RD1)
    core_txn(PUSH, 16'h0033);
    @(posedge clk); #1;
    core_req = 1'b1; core_op = POP2;
    @(posedge clk); #1;
    check("mid_rst_no_ack_rd0", 32'(core_ack), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_no_ack_rd1", 32'(core_ack), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_ack_done", 32'(core_ack), 32'd0);
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_core_b", 32'(core_b), 32'd0);
    core_req = 1'b0; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_no_ack", 32'(core_ack), 32'd0);
    core_txn(PUSH, 16'h0044);
    core_txn(CLEAR, 16'h0);

    // Fill to full, overflow, then pop the top
    for (int i = 0; i < 256; i++) core_txn(PUSH, 16'(i));
    check("full_depth", 32'(depth), 32'd256);
    core_txn(PUSH, 16'hDEAD);
    core_txn(POP1, 16'h0);
    check("pop_after_full", 32'(core_b), 32'h000000FF);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) dbg_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 16'($urandom));
      else if (r < 6) core_txn(PUSH, 16'($urandom));
      else if (r < 9) core_txn(1'($urandom_range(0, 1)) ? POP2 : POP1, 16'h0);
      else if ($urandom_range(0, 7) == 0) core_txn(CLEAR, 16'h0);
      else core_txn(POP1, 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uxn_stack_ctrl.md
Name: uxn_stack_ctrl

Overview:
Owns the data-stack RAM and sequences every access to it. Core execute unit issues POP1/POP2/PUSH/CLEAR transactions; a debug port reads/writes entries by absolute index. One RAM access per cycle; a two-way round-robin arbiter picks core vs debug when both request. Tracks stack depth and flags underflow/overflow instead of wrapping.

Parameters:
DATA_W, 16, stack entry width
DEPTH_LOG2, 8, log2 of stack entries (DEPTH = 256)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
core_req  in  1  core transaction request; held until core_ack
core_op  in  2  00 POP1, 01 POP2, 10 PUSH, 11 CLEAR
core_wdata  in  DATA_W  PUSH data
core_ack  out  1  one-cycle completion pulse
core_err  out  1  valid with core_ack; 1 = underflow/overflow, no state change
core_a  out  DATA_W  POP2: entry below top; POP1: 0
core_b  out  DATA_W  POP1/POP2: top entry
dbg_req  in  1  debug request; held until dbg_ack
dbg_we  in  1  1 write, 0 read
dbg_idx  in  DEPTH_LOG2  absolute index (0 = bottom)
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  read data, valid with dbg_ack
depth  out  DEPTH_LOG2+1  current entry count, 0..DEPTH

Behaviour:
- Only clk; reset synchronous, active-high.
- Reset: FSM=IDLE, depth=0, rr_last=DEBUG (core wins first tie), all acks/err 0, core_a/core_b/dbg_rdata 0. RAM contents not cleared; bench reads only below depth.
- RAM: internal DEPTH x DATA_W array, synchronous read (data one cycle after address), one read or write per cycle.
- FSM states: IDLE, RD0, RD1, WR, DONE. Requests sampled only in IDLE. DONE lasts one cycle, asserts exactly one ack, then returns to IDLE; a held req is re-sampled in the next IDLE cycle (min 1 idle cycle between transactions).
- Arbitration in IDLE: one requester -> grant it; both -> grant the one not in rr_last; rr_last updates on every grant. Loser's request stays pending, no ack.
- Latency (cycle where req first sampled in IDLE = c0; ack in DONE):
  PUSH: IDLE->WR->DONE, ack c2; write addr depth, depth+1 at end of WR.
  POP1: IDLE->RD0->DONE, ack c2; read addr depth-1; core_b=data, core_a=0; depth-1.
  POP2: IDLE->RD0->RD1->DONE, ack c3; RD0 reads depth-1 (->core_b), RD1 reads depth-2 (->core_a); depth-2.
  CLEAR: IDLE->DONE, ack c1; depth=0.
  Debug write: IDLE->WR->DONE, ack c2. Debug read: IDLE->RD0->DONE, ack c2. Debug never changes depth.
- Errors (decided in IDLE, go straight to DONE, ack c1, core_err=1, no RAM access, depth and core_a/core_b unchanged): POP1 with depth<1; POP2 with depth<2; PUSH with depth==DEPTH. Debug index >= depth is legal (raw RAM access, no error).
- core_a/core_b/dbg_rdata registered, hold value until next successful transaction of that kind.
- core_err is 0 whenever core_ack is 0.
- Debug write to an index the core is about to pop is serialised by the FSM; the later transaction sees the earlier write.
- Reset mid-transaction: aborts, no ack that cycle, depth=0, FSM IDLE next cycle.
- depth is updated at the end of the last access state; visible at DONE cycle.

Test Plan:
- Reset, PUSH 0x0003, PUSH 0x0005, POP2 -> acks at c2, c2, c3; core_a=0x0003, core_b=0x0005, depth 2 then 0.
- depth=0, POP1 -> ack at c1, core_err=1, depth stays 0; then POP2 with depth=1 -> core_err=1, depth 1.
- Fill 256 PUSHes (value=i) -> depth=256, 257th PUSH core_err=1; POP1 -> core_b=0x00FF, depth=255.
- core_req and dbg_req (read idx 0) asserted together from reset, both held -> core granted first, debug ack in the following transaction; repeat tie -> grant alternates.
- Stack [0x0011,0x0022]; debug write idx 1 = 0xBEEF, then POP1 -> core_b=0xBEEF; debug read idx 0 -> dbg_rdata=0x0011, depth unchanged.
- POP2 in progress (RD1), rst high one cycle -> no core_ack, depth=0; CLEAR after PUSH -> ack c1, depth=0.
